// File: rtl/lsu_pkg.sv
// Shared types and encodings for the RV32I load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Data-bus request payload captured at accept time.
  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [BE_W-1:0]   be;
    logic [XLEN-1:0]   wdata;
  } dbus_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational access checks, byte enables, store lane placement and load extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic            i_is_load,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  output logic            o_err,
  output logic [BE_W-1:0] o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_err = 1'b0;
    if (i_is_load) begin
      case (i_funct3)
        FUNCT3_LB, FUNCT3_LBU: o_err = 1'b0;
        FUNCT3_LH, FUNCT3_LHU: o_err = i_addr_lo[0];
        FUNCT3_LW:             o_err = |i_addr_lo;
        default:               o_err = 1'b1;
      endcase
    end else if (i_is_store) begin
      case (i_funct3)
        FUNCT3_SB: o_err = 1'b0;
        FUNCT3_SH: o_err = i_addr_lo[0];
        FUNCT3_SW: o_err = |i_addr_lo;
        default:   o_err = 1'b1;
      endcase
    end
  end

  // Size comes from funct3[1:0]; both be and lane data are replicated/shifted by it.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_funct3[1:0])
      2'd0: begin
        o_be    = BE_W'(4'b0001 << i_addr_lo);
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'd1: begin
        o_be    = BE_W'(4'b0011 << i_addr_lo);
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_funct3)
      FUNCT3_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
      FUNCT3_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
      FUNCT3_LBU: o_ld_data = {24'd0, w_byte};
      FUNCT3_LHU: o_ld_data = {16'd0, w_half};
      default:    o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/gnt/rvalid data-bus access at a time, stalling the pipeline while busy.
module lsu
  import lsu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [BE_W-1:0] dbus_be_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i
);

  lsu_state_e      r_state;
  lsu_state_e      w_state_nxt;
  dbus_req_t       r_req;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic [XLEN-1:0] r_rdata;

  logic            w_is_load;
  logic            w_is_store;
  logic            w_align_err;
  logic            w_idle;
  logic            w_accept;
  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_ld_data;

  // Read wins when decode raises both controls.
  assign w_is_load  = mem_read_i;
  assign w_is_store = mem_write_i & ~mem_read_i;
  assign w_idle     = (r_state == LSU_IDLE);
  assign err_o      = w_idle & w_align_err;
  assign w_accept   = w_idle & (w_is_load | w_is_store) & ~w_align_err;

  lsu_align u_align (
    .i_is_load    (w_is_load),
    .i_is_store   (w_is_store),
    .i_funct3     (funct3_i),
    .i_addr_lo    (addr_i[1:0]),
    .i_wdata      (wdata_i),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (dbus_rdata_i),
    .o_err        (w_align_err),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= LSU_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_o     = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        if (w_accept) begin
          w_state_nxt = LSU_REQ;
          stall_o     = 1'b1;
        end
      end
      LSU_REQ: begin
        stall_o = 1'b1;
        if (dbus_gnt_i) w_state_nxt = r_req.we ? LSU_DONE : LSU_WAIT;
      end
      LSU_WAIT: begin
        stall_o = 1'b1;
        if (dbus_rvalid_i) w_state_nxt = LSU_DONE;
      end
      LSU_DONE: w_state_nxt = LSU_IDLE;
      default:  w_state_nxt = LSU_IDLE;
    endcase
  end

  // Bus payload is frozen from accept until the next accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_req     <= '0;
      r_funct3  <= 3'd0;
      r_addr_lo <= 2'd0;
      r_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_req.we    <= w_is_store;
        r_req.addr  <= {addr_i[XLEN-1:2], 2'b00};
        r_req.be    <= w_be;
        r_req.wdata <= w_wdata;
        r_funct3    <= funct3_i;
        r_addr_lo   <= addr_i[1:0];
      end
      if ((r_state == LSU_WAIT) && dbus_rvalid_i) r_rdata <= w_ld_data;
    end
  end

  assign valid_o      = (r_state == LSU_DONE);
  assign dbus_req_o   = (r_state == LSU_REQ);
  assign dbus_we_o    = r_req.we;
  assign dbus_addr_o  = r_req.addr;
  assign dbus_be_o    = r_req.be;
  assign dbus_wdata_o = r_req.wdata;
  assign rdata_o      = r_rdata;

endmodule

// File: tb/tb_lsu.sv
// Directed and randomized checks of lsu against an arithmetic reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, valid_o, err_o;
  logic [31:0] rdata_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  lsu dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .valid_o(valid_o), .rdata_o(rdata_o), .err_o(err_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes.
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit model_err(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (!ld && f3 >= 3) return 1'b1;
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    longint m;
    m = ((longint'(1) << size_of(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (size_of(f3))
      1:       return 32'(longint'(wd & 32'hFF) * 64'h01010101);
      2:       return 32'(longint'(wd & 32'hFFFF) * 64'h00010001);
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    longint v, mask;
    int nbits;
    if (size_of(f3) == 4) return word;
    nbits = 8 * size_of(f3);
    mask  = (longint'(1) << nbits) - 1;
    v     = (longint'(word) >> (8 * (a % 4))) & mask;
    if (f3 < 4 && ((v >> (nbits - 1)) & 1) == 1) v = v | (~mask);
    return 32'(v);
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // One legal access: gd wait cycles before gnt, rd wait cycles before rvalid.
  task automatic do_access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rw,
                           input int gd, input int rd);
    mem_read_i = ld; mem_write_i = !ld; funct3_i = f3; addr_i = a; wdata_i = wd;
    #1;
    chk("acc_err", 32'(err_o), 32'd0);
    chk("acc_stall_c0", 32'(stall_o), 32'd1);
    chk("acc_req_c0", 32'(dbus_req_o), 32'd0);
    tick();
    for (int c = 0; c <= gd; c++) begin
      chk("req_req", 32'(dbus_req_o), 32'd1);
      chk("req_stall", 32'(stall_o), 32'd1);
      chk("req_we", 32'(dbus_we_o), 32'(!ld));
      chk("req_addr", dbus_addr_o, {a[31:2], 2'b00});
      if (!ld) begin
        chk("req_be", 32'(dbus_be_o), 32'(model_be(f3, a)));
        chk("req_wdata", dbus_wdata_o, model_wdata(f3, wd));
      end
      if (c == gd) dbus_gnt_i = 1'b1;
      tick();
      dbus_gnt_i = 1'b0;
    end
    if (ld) begin
      for (int c = 0; c <= rd; c++) begin
        chk("wait_req", 32'(dbus_req_o), 32'd0);
        chk("wait_stall", 32'(stall_o), 32'd1);
        chk("wait_valid", 32'(valid_o), 32'd0);
        if (c == rd) begin dbus_rvalid_i = 1'b1; dbus_rdata_i = rw; end
        tick();
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = $urandom;
      end
      exp_rdata = model_load(f3, a, rw);
    end
    chk("done_valid", 32'(valid_o), 32'd1);
    chk("done_stall", 32'(stall_o), 32'd0);
    chk("done_req", 32'(dbus_req_o), 32'd0);
    chk("done_rdata", rdata_o, exp_rdata);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    tick();
    chk("idle_valid", 32'(valid_o), 32'd0);
    chk("idle_stall", 32'(stall_o), 32'd0);
  endtask

  task automatic do_error(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    mem_read_i = ld; mem_write_i = !ld; funct3_i = f3; addr_i = a; wdata_i = $urandom;
    #1;
    chk("err_err", 32'(err_o), 32'd1);
    chk("err_stall", 32'(stall_o), 32'd0);
    chk("err_req", 32'(dbus_req_o), 32'd0);
    tick();
    chk("err_req_next", 32'(dbus_req_o), 32'd0);
    chk("err_valid_next", 32'(valid_o), 32'd0);
    chk("err_still_err", 32'(err_o), 32'd1);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    #1;
  endtask

  initial begin
    bit          ld;
    logic [2:0]  f3;
    logic [31:0] a;
    mem_read_i = 0; mem_write_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
    dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = 0;
    exp_rdata = 32'd0;
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dbus_req_o), 32'd0);
    chk("rst_we", 32'(dbus_we_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_addr", dbus_addr_o, 32'd0);
    chk("rst_be", 32'(dbus_be_o), 32'd0);
    chk("rst_wdata", dbus_wdata_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rst_n_i = 1'b1;
    tick();

    // Directed cases from the access table.
    do_access(1, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0);
    chk("lw_rdata", rdata_o, 32'hDEADBEEF);
    do_access(1, 3'd0, 32'h103, 32'd0, 32'h80FF0000, 0, 0);
    chk("lb_rdata", rdata_o, 32'hFFFFFF80);
    do_access(1, 3'd4, 32'h103, 32'd0, 32'h80FF0000, 1, 1);
    chk("lbu_rdata", rdata_o, 32'h00000080);
    do_access(1, 3'd1, 32'h102, 32'd0, 32'h80FF0000, 0, 2);
    chk("lh_rdata", rdata_o, 32'hFFFF80FF);
    do_access(0, 3'd0, 32'h201, 32'h12345678, 32'd0, 0, 0);
    chk("sb_keeps_rdata", rdata_o, 32'hFFFF80FF);
    do_access(0, 3'd1, 32'h302, 32'hCAFEBABE, 32'd0, 4, 0);
    do_error(1, 3'd2, 32'h102);
    do_error(0, 3'd1, 32'h301);
    do_error(1, 3'd3, 32'h100);
    do_error(0, 3'd4, 32'h100);

    // Read wins when both controls are raised.
    mem_read_i = 1; mem_write_i = 1; funct3_i = 3'd2; addr_i = 32'h400; wdata_i = 32'h1;
    tick();
    chk("prio_we", 32'(dbus_we_o), 32'd0);
    chk("prio_req", 32'(dbus_req_o), 32'd1);
    dbus_gnt_i = 1; tick(); dbus_gnt_i = 0;
    dbus_rvalid_i = 1; dbus_rdata_i = 32'h0BADF00D; tick(); dbus_rvalid_i = 0;
    chk("prio_valid", 32'(valid_o), 32'd1);
    chk("prio_rdata", rdata_o, 32'h0BADF00D);
    exp_rdata = 32'h0BADF00D;
    mem_read_i = 0; mem_write_i = 0;
    tick();

    // Reset during WAIT, then a late rvalid.
    mem_read_i = 1; funct3_i = 3'd2; addr_i = 32'h500;
    tick();
    dbus_gnt_i = 1; tick(); dbus_gnt_i = 0;
    chk("rstw_in_wait", 32'(stall_o), 32'd1);
    mem_read_i = 0;
    rst_n_i = 1'b0;
    #1;
    chk("rstw_req", 32'(dbus_req_o), 32'd0);
    chk("rstw_valid", 32'(valid_o), 32'd0);
    chk("rstw_rdata", rdata_o, 32'd0);
    tick();
    rst_n_i = 1'b1;
    dbus_rvalid_i = 1; dbus_rdata_i = 32'h55AA55AA;
    tick();
    dbus_rvalid_i = 0;
    chk("rstw_late_valid", 32'(valid_o), 32'd0);
    chk("rstw_late_stall", 32'(stall_o), 32'd0);
    chk("rstw_late_rdata", rdata_o, 32'd0);
    exp_rdata = 32'd0;
    tick();

    // Randomized mix of loads, stores and illegal accesses.
    for (int i = 0; i < 80; i++) begin
      ld = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        if (ld) begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
          endcase
        end else begin
          f3 = 3'($urandom_range(0, 2));
        end
      end else begin
        f3 = 3'($urandom);
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~(32'(size_of(f3)) - 32'd1);
      if (model_err(ld, f3, a))
        do_error(ld, f3, a);
      else
        do_access(ld, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
